// File: rtl/bist_controller_if.sv
// Bus between the BIST sequencer and its surroundings: run request, MISR contents,
// the pattern-generator/scan/MISR enables and the run result.
interface bist_controller_if #(
    parameter int SIG_W = 4
);
    logic             bist_start;
    logic [SIG_W-1:0] misr_sig;
    logic             bist_mode;
    logic             scan_en;
    logic             lfsr_init;
    logic             lfsr_en;
    logic             misr_init;
    logic             misr_en;
    logic             bist_end;
    logic             pass_nfail;

    modport master (
        input  bist_start, misr_sig,
        output bist_mode, scan_en, lfsr_init, lfsr_en,
               misr_init, misr_en, bist_end, pass_nfail
    );

    modport slave (
        output bist_start, misr_sig,
        input  bist_mode, scan_en, lfsr_init, lfsr_en,
               misr_init, misr_en, bist_end, pass_nfail
    );
endinterface

// File: rtl/bist_controller.sv
// Per-scan BIST sequencer: seeds the LFSR, shifts/captures N_PATTERNS patterns, checks the MISR.
// Optional macro BIST_ABORT_EN: dropping bist_start mid-run returns to IDLE without a result.
module bist_controller #(
    parameter int               SCAN_LEN   = 4,
    parameter int               N_PATTERNS = 10,
    parameter int               SIG_W      = 4,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = SIG_W'('hA),
    parameter int               CNT_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    bist_controller_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SHIFT,
        CAPTURE,
        COMPARE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SCAN_LEN - 1);
    localparam logic [CNT_W-1:0] PAT_TOTAL  = CNT_W'(N_PATTERNS);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] shift_cnt;
    logic [CNT_W-1:0] shift_next;
    logic [CNT_W-1:0] pat_cnt;
    logic [CNT_W-1:0] pat_next;
    logic             end_q;
    logic             end_next;
    logic             pass_q;
    logic             pass_next;
    logic             abort;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shift_cnt <= '0;
            pat_cnt   <= '0;
            end_q     <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state     <= state_next;
            shift_cnt <= shift_next;
            pat_cnt   <= pat_next;
            end_q     <= end_next;
            pass_q    <= pass_next;
        end
    end

`ifdef BIST_ABORT_EN
    assign abort = !bus.bist_start;
`else
    assign abort = 1'b0;
`endif

    // The final SHIFT pass (pat_cnt == N_PATTERNS) only unloads the last response.
    always_comb begin
        state_next = state;
        shift_next = shift_cnt;
        pat_next   = pat_cnt;
        end_next   = end_q;
        pass_next  = pass_q;
        case (state)
            IDLE: begin
                end_next  = 1'b0;
                pass_next = 1'b0;
                if (bus.bist_start) begin
                    state_next = INIT;
                end
            end
            INIT: begin
                shift_next = '0;
                pat_next   = '0;
                state_next = SHIFT;
            end
            SHIFT: begin
                if (shift_cnt == SHIFT_LAST) begin
                    state_next = (pat_cnt < PAT_TOTAL) ? CAPTURE : COMPARE;
                end else begin
                    shift_next = shift_cnt + CNT_W'(1);
                end
            end
            CAPTURE: begin
                pat_next   = pat_cnt + CNT_W'(1);
                shift_next = '0;
                state_next = SHIFT;
            end
            COMPARE: begin
                end_next   = 1'b1;
                pass_next  = (bus.misr_sig == GOLDEN_SIG);
                state_next = DONE;
            end
            DONE: begin
                if (!bus.bist_start) begin
                    end_next   = 1'b0;
                    pass_next  = 1'b0;
                    shift_next = '0;
                    pat_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort && (state inside {INIT, SHIFT, CAPTURE, COMPARE})) begin
            state_next = IDLE;
            shift_next = '0;
            pat_next   = '0;
            end_next   = 1'b0;
            pass_next  = 1'b0;
        end
    end

    always_comb begin
        bus.bist_mode = (state != IDLE);
        bus.scan_en   = 1'b0;
        bus.lfsr_init = 1'b0;
        bus.lfsr_en   = 1'b0;
        bus.misr_init = 1'b0;
        bus.misr_en   = 1'b0;
        case (state)
            INIT: begin
                bus.lfsr_init = 1'b1;
                bus.misr_init = 1'b1;
            end
            SHIFT: begin
                bus.scan_en = 1'b1;
                bus.lfsr_en = 1'b1;
                bus.misr_en = 1'b1;
            end
            default: begin
                bus.scan_en = 1'b0;
            end
        endcase
    end

    assign bus.bist_end   = end_q;
    assign bus.pass_nfail = pass_q;

endmodule
